// File: rtl/ahbl2apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: AHB-Lite slave side and APB3 master side.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface ahbl2apb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport slave (
    input  hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahbl2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB SETUP/ACCESS per accepted single word transfer,
// AHB data phase stretched until the completer answers, PSLVERR and bad sizes mapped to ERROR.
module ahbl2apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               hclk,
  input logic               hresetn,
  ahbl2apb_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    DONE   = 3'd4,
    ERR1   = 3'd5,
    ERR2   = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  logic              accept;
  logic              size_err;
  logic              ready_state;
  logic              start;
  logic              psel_d;
  logic              penable_d;
  logic              hreadyout_d;
  logic              hresp_d;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              unused_ok;

  // hburst/hprot are ignored and htrans[0] only separates SEQ from NONSEQ.
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.htrans[0]};

  assign accept      = bus.hsel & bus.htrans[1] & bus.hready;
  assign size_err    = (bus.hsize != 3'b010);
  assign ready_state = (state == IDLE) || (state == DONE) || (state == ERR2);
  assign start       = ready_state & accept;

  always_comb begin
    state_next  = state;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    hreadyout_d = 1'b0;
    hresp_d     = 1'b0;
    case (state)
      IDLE, DONE, ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = (state == ERR2);
        if (accept) begin
          if (size_err)
            state_next = ERR1;
          else if (bus.hwrite)
            state_next = WWAIT;
          else
            state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      WWAIT: state_next = SETUP;
      SETUP: begin
        psel_d     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (bus.pready)
          state_next = bus.pslverr ? ERR1 : DONE;
      end
      ERR1: begin
        hresp_d    = 1'b1;
        state_next = ERR2;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write data only exists in the AHB data phase, which is the WWAIT cycle.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        paddr_q  <= bus.haddr;
        pwrite_q <= bus.hwrite;
      end
      if (state == WWAIT)
        pwdata_q <= bus.hwdata;
      if ((state == ACCESS) && bus.pready && !bus.pslverr && !pwrite_q)
        hrdata_q <= bus.prdata;
    end
  end

  assign bus.psel      = psel_d;
  assign bus.penable   = penable_d;
  assign bus.hreadyout = hreadyout_d;
  assign bus.hresp     = hresp_d;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.hrdata    = hrdata_q;

endmodule
